// File: rtl/bsg_noc_flit_deserializer.sv
// bsg_noc_flit_deserializer
//
// Reassembles a wide packet from a stream of narrow flits. Flits arrive on a
// then-ready link (v_i / data_i, acknowledged by yumi_o). Flit 0 lands in the
// least-significant slice of data_o. Any bits of the last flit that lie above
// wide_width_p-1 are dropped. Once the packet is complete it is presented on
// a valid/ready output (v_o / data_o / ready_and_i).
//
// Handshake semantics:
//   input side : a flit is consumed on a rising edge where yumi_o=1. yumi_o
//                is only raised while v_i=1, so the sender may look at it
//                combinationally.
//   output side: a packet transfers on a rising edge where v_o & ready_and_i.
//                While v_o=1 and ready_and_i=0, data_o holds its value.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   v_i          flit valid
//   data_i       flit payload [flit_width_p-1:0]
//   yumi_o       flit consumed this cycle
//   v_o          reassembled packet valid
//   data_o       reassembled packet [wide_width_p-1:0]
//   ready_and_i  downstream ready
//   pkt_count_o  16-bit count of output handshakes, wraps at 0xFFFF
//                (present only with BSG_NOC_FLIT_DESER_PKT_CNT_EN defined)
//   dbg_state_o  current FSM state (0 = COLLECT, 1 = FULL)
//
// Optional feature macro: BSG_NOC_FLIT_DESER_PKT_CNT_EN

module bsg_noc_flit_deserializer #(
  parameter int wide_width_p = 80,
  parameter int flit_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [flit_width_p-1:0] data_i,
  output logic                    yumi_o,
  output logic                    v_o,
  output logic [wide_width_p-1:0] data_o,
  input  logic                    ready_and_i,
`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
  output logic [15:0]             pkt_count_o,
`endif
  output logic                    dbg_state_o
);

  localparam int num_flits_raw_lp = (wide_width_p + flit_width_p - 1) / flit_width_p;
  localparam int num_flits_lp     = (num_flits_raw_lp < 1) ? 1 : num_flits_raw_lp;
  localparam int cnt_width_lp     = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e                   state_r, state_n;
  logic [cnt_width_lp-1:0]  cnt_r, cnt_n;
  logic [wide_width_p-1:0]  data_r;
  logic                     yumi;
  logic                     out_hs;
  logic                     last_flit;

  // Some data_i bits are never stored when the packet is narrower than one
  // flit; fold them here so that is visibly intentional.
  logic unused_data_bits;
  assign unused_data_bits = ^data_i;

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    last_flit = (cnt_r == cnt_width_lp'(num_flits_lp - 1));
    out_hs    = (state_r == FULL) & ready_and_i;
    // Gating with reset_n_i keeps yumi_o low while reset is held, even if
    // the sender is already presenting a flit.
    yumi      = v_i & reset_n_i & ((state_r == COLLECT) | out_hs);

    if (yumi) begin
      cnt_n = last_flit ? '0 : cnt_r + cnt_width_lp'(1);
    end

    case (state_r)
      COLLECT: begin
        if (yumi && last_flit) state_n = FULL;
      end
      FULL: begin
        // In FULL the counter sits at 0, so a flit accepted alongside the
        // output handshake becomes flit 0 of the next packet. With a single
        // flit per packet that flit completes it immediately.
        if (out_hs) state_n = (yumi && last_flit) ? FULL : COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= COLLECT;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Each output bit belongs to exactly one flit slot; it is written only
  // when that slot's flit is consumed. Bits of the last flit beyond the
  // packet width have no destination and fall away here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
    end else if (yumi) begin
      for (int b = 0; b < wide_width_p; b++) begin
        if (cnt_r == cnt_width_lp'(b / flit_width_p)) begin
          data_r[b] <= data_i[b % flit_width_p];
        end
      end
    end
  end

`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
  logic [15:0] pkt_count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_count_r <= '0;
    end else if (out_hs) begin
      pkt_count_r <= pkt_count_r + 16'd1;
    end
  end

  assign pkt_count_o = pkt_count_r;
`endif

  assign yumi_o      = yumi;
  assign v_o         = (state_r == FULL);
  assign data_o      = data_r;
  assign dbg_state_o = state_r;

endmodule

// File: tb/tb_bsg_noc_flit_deserializer.sv
// Bench for bsg_noc_flit_deserializer.
// Main instance: default 80/32 parameters, driven by directed and random
// stimulus, checked by a packet-level reference model and a scoreboard.
// Second instance: 16/32 (one flit per packet), directed checks.

module tb_bsg_noc_flit_deserializer;

  localparam int WIDE = 80;
  localparam int FLIT = 32;
  localparam int NF   = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic            v_i;
  logic [FLIT-1:0] data_i;
  logic            yumi_o;
  logic            v_o;
  logic [WIDE-1:0] data_o;
  logic            ready_and_i;
  logic            dbg_state;

  // ---------------- narrow DUT signals ----------------
  logic            d1_v_i;
  logic [31:0]     d1_data_i;
  logic            d1_yumi_o;
  logic            d1_v_o;
  logic [15:0]     d1_data_o;
  logic            d1_ready;
  logic            d1_dbg_state;

`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
  logic [15:0]     pkt_count;
  logic [15:0]     d1_pkt_count;
`endif

  bsg_noc_flit_deserializer #(.wide_width_p(WIDE), .flit_width_p(FLIT)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (v_i),
    .data_i      (data_i),
    .yumi_o      (yumi_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .ready_and_i (ready_and_i),
`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
    .pkt_count_o (pkt_count),
`endif
    .dbg_state_o (dbg_state)
  );

  bsg_noc_flit_deserializer #(.wide_width_p(16), .flit_width_p(32)) dut1 (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .v_i         (d1_v_i),
    .data_i      (d1_data_i),
    .yumi_o      (d1_yumi_o),
    .v_o         (d1_v_o),
    .data_o      (d1_data_o),
    .ready_and_i (d1_ready),
`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
    .pkt_count_o (d1_pkt_count),
`endif
    .dbg_state_o (d1_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [WIDE-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;

  // Reference model: a packet is just the list of accepted flits laid side
  // by side, flit 0 lowest, cut to WIDE bits.
  logic [FLIT*NF-1:0] acc;
  int  nflit   = 0;
  bit  pending = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [FLIT-1:0] d, input bit rdy);
    bit exp_yumi;
    @(posedge clk); #1;
    v_i = v; data_i = d; ready_and_i = rdy;
    exp_yumi = v && (!pending || rdy);
    @(negedge clk);
    check("yumi", 128'(yumi_o), 128'(exp_yumi));
    check("v_o", 128'(v_o), 128'(pending));
    // advance the model to what the coming edge does
    if (pending && rdy) pending = 1'b0;
    if (exp_yumi) begin
      acc[nflit*FLIT +: FLIT] = d;
      nflit++;
      if (nflit == NF) begin
        exp_q.push_back(acc[WIDE-1:0]);
        nflit   = 0;
        pending = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; v_i = 1'b1; data_i = $urandom; ready_and_i = 1'b1;
    #2;
    check("rst_yumi", 128'(yumi_o), 128'(0));
    check("rst_v_o", 128'(v_o), 128'(0));
    check("rst_data", 128'(data_o), 128'(0));
    exp_q.delete();
    pending = 1'b0; nflit = 0; hs_cnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1; v_i = 1'b0;
  endtask

  task automatic step1(input bit v, input logic [31:0] d, input bit rdy);
    @(posedge clk); #1;
    d1_v_i = v; d1_data_i = d; d1_ready = rdy;
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  logic [WIDE-1:0] prev_data;
  bit              prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [WIDE-1:0] exp_pkt;
    if (reset_n) begin
      if (prev_stall) check("data_stable", 128'(data_o), 128'(prev_data));
      if (v_o && ready_and_i) begin
`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
        check("pkt_count", 128'(pkt_count), 128'(hs_cnt[15:0]));
`endif
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pkt_unexpected: got %h expected none", data_o);
        end else begin
          exp_pkt = exp_q.pop_front();
          check("pkt_data", 128'(data_o), 128'(exp_pkt));
        end
      end
      prev_stall = v_o && !ready_and_i;
      prev_data  = data_o;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h0;
    v_i = 1'b0; data_i = '0; ready_and_i = 1'b0;
    d1_v_i = 1'b0; d1_data_i = '0; d1_ready = 1'b0;
    acc = '0;

    // reset state, with a flit offered during reset
    v_i = 1'b1; d1_v_i = 1'b1;
    #2;
    check("init_yumi", 128'(yumi_o), 128'(0));
    check("init_v_o", 128'(v_o), 128'(0));
    check("init_data", 128'(data_o), 128'(0));
    check("init_d1_yumi", 128'(d1_yumi_o), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1; v_i = 1'b0; d1_v_i = 1'b0;

    // basic packet
    step(1'b1, 32'h1111_1111, 1'b1);
    step(1'b1, 32'h2222_2222, 1'b1);
    step(1'b1, 32'h0000_BEEF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("basic_v_o", 128'(v_o), 128'(1));
    check("basic_data", 128'(data_o), 128'(80'hBEEF_2222_2222_1111_1111));

    // backpressure: complete, stall 5 cycles with flits offered, release
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    step(1'b1, $urandom, 1'b1);
    step(1'b1, $urandom, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // streaming: 4 packets back to back
    #1; h0 = hs_cnt;
    for (int i = 0; i < 4 * NF; i++) step(1'b1, $urandom, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("stream_handshakes", 128'(hs_cnt - h0), 128'(4));

    // mid-packet reset
    step(1'b1, 32'h5555_5555, 1'b1);
    step(1'b1, 32'h6666_6666, 1'b1);
    do_reset();
    step(1'b1, 32'hAAAA_0001, 1'b1);
    step(1'b1, 32'hBBBB_0002, 1'b1);
    step(1'b1, 32'hCCCC_0003, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("post_reset_data", 128'(data_o), 128'(80'h0003_BBBB_0002_AAAA_0001));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'(0));

    // one flit per packet, upper flit bits discarded
    step1(1'b1, 32'hCAFE_1234, 1'b1);
    check("n1_yumi", 128'(d1_yumi_o), 128'(1));
    check("n1_v_o_early", 128'(d1_v_o), 128'(0));
    step1(1'b1, 32'h9876_ABCD, 1'b1);
    check("n1_v_o", 128'(d1_v_o), 128'(1));
    check("n1_data", 128'(d1_data_o), 128'(16'h1234));
    check("n1_yumi_b2b", 128'(d1_yumi_o), 128'(1));
    step1(1'b0, 32'h0, 0);
    check("n1_data_b2b", 128'(d1_data_o), 128'(16'hABCD));
    check("n1_stall_v_o", 128'(d1_v_o), 128'(1));
    step1(1'b1, 32'h1357_2468, 1'b0);
    check("n1_stall_yumi", 128'(d1_yumi_o), 128'(0));
    check("n1_stall_data", 128'(d1_data_o), 128'(16'hABCD));
    step1(1'b0, 32'h0, 1'b1);
    step1(1'b0, 32'h0, 1'b1);
    check("n1_idle_v_o", 128'(d1_v_o), 128'(0));

`ifdef BSG_NOC_FLIT_DESER_PKT_CNT_EN
    // counter wrap: 65537 handshakes leave the count at 1
    do_reset();
    for (int i = 0; i < 65537; i++) step1(1'b1, $urandom, 1'b1);
    step1(1'b0, 32'h0, 1'b1);
    step1(1'b0, 32'h0, 1'b1);
    check("pkt_count_wrap", 128'(d1_pkt_count), 128'(16'd1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_noc_flit_deserializer.md
BSG_NOC_FLIT_DESERIALIZER -- requirements
Module: bsg_noc_flit_deserializer

Interface
REQ-001 SHALL have parameter wide_width_p, default 80, width of the reassembled packet in bits.
REQ-002 SHALL have parameter flit_width_p, default 32, width of one incoming flit in bits.
REQ-003 SHALL have derived localparam num_flits_lp = ceil(wide_width_p/flit_width_p), minimum 1.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state is sampled on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1, reset; reset is asynchronous and active-low.
REQ-006 SHALL have port v_i, input, 1, flit valid from the then-ready link.
REQ-007 SHALL have port data_i, input, flit_width_p, flit payload.
REQ-008 SHALL have port yumi_o, output, 1, flit consumed this cycle (then-ready acknowledge).
REQ-009 SHALL have port v_o, output, 1, reassembled packet valid.
REQ-010 SHALL have port data_o, output, wide_width_p, reassembled packet.
REQ-011 SHALL have port ready_and_i, input, 1, downstream ready; a packet transfers when v_o & ready_and_i.

Function
REQ-012 SHALL implement a two-state FSM with states COLLECT and FULL, reset state COLLECT.
REQ-013 SHALL assert yumi_o = v_i & (state==COLLECT | (state==FULL & ready_and_i)); yumi_o is never asserted without v_i.
REQ-014 SHALL hold a flit counter of width max(1, clog2(num_flits_lp)), reset 0, incremented on each yumi_o.
REQ-015 SHALL store flit k (k = counter value at yumi) into data_o bits [k*flit_width_p +: flit_width_p]; flit 0 is the least-significant flit.
REQ-016 SHALL discard the bits of the last flit that lie above wide_width_p-1.
REQ-017 SHALL, on yumi of flit num_flits_lp-1, wrap the counter to 0 and enter FULL on the next cycle.
REQ-018 SHALL assert v_o only in FULL; data_o SHALL be stable while v_o=1 and ready_and_i=0.
REQ-019 SHALL leave FULL for COLLECT on v_o & ready_and_i when no flit is consumed in the same cycle.
REQ-020 SHALL, on a simultaneous output handshake and yumi in FULL, write that flit as flit 0 of the next packet and set the counter to 1, or re-enter FULL if num_flits_lp==1; no bubble cycle is inserted.
REQ-021 SHALL give a latency of 1 cycle from yumi of the last flit to v_o=1.
REQ-022 SHALL sustain one flit per cycle, i.e. one packet every num_flits_lp cycles with continuous v_i and ready_and_i=1.
REQ-023 SHALL have no combinational path from data_i to data_o.

Reset
REQ-024 SHALL, while reset_n_i=0, force the state to COLLECT, the counter to 0, v_o=0 and yumi_o=0, independent of clk_i.
REQ-025 SHALL reset the data register to all zeros.
REQ-026 SHALL discard any partially collected or unacknowledged packet when reset is asserted mid-operation.
REQ-027 SHALL treat reset deassertion as synchronous to clk_i; the first flit can be consumed in the first clock edge after deassertion.

Configuration
REQ-028 SHALL support macro BSG_NOC_FLIT_DESER_PKT_CNT_EN.
REQ-029 SHALL, when that macro is defined, add output pkt_count_o [15:0], reset 0, incremented on each v_o & ready_and_i, wrapping 0xFFFF to 0x0000.
REQ-030 SHALL, when the macro is undefined, omit pkt_count_o and its logic, with all other behaviour identical.

Verification
REQ-031 SHALL test the default parameters: flits 0x11111111, 0x22222222, 0x0000BEEF on consecutive cycles with ready_and_i=1 -> v_o=1 on the next cycle, data_o=0xBEEF_22222222_11111111.
REQ-032 SHALL test backpressure: packet complete with ready_and_i=0 for 5 cycles while v_i=1 -> yumi_o=0 and data_o stable; on ready_and_i=1, handshake and yumi of the next flit 0 occur in the same cycle.
REQ-033 SHALL test streaming: 4 packets of 3 flits with continuous v_i and ready_and_i=1 -> 4 handshakes in 12 cycles, data matching, no bubbles.
REQ-034 SHALL test mid-packet reset: assert reset_n_i=0 after 2 flits, then send 3 new flits -> the output equals only the new flits.
REQ-035 SHALL test num_flits_lp=1 (wide_width_p=16, flit_width_p=32): flit 0xCAFE1234 -> data_o=0x1234 one cycle later.
REQ-036 SHALL test with BSG_NOC_FLIT_DESER_PKT_CNT_EN defined: 65537 handshakes -> pkt_count_o=1.
